// File: rtl/holy_axi_pkg.sv
// Shared types and AXI constants for the holy core read-channel arbiter.
package holy_axi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } rd_state_e;

  localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

endpackage

// File: rtl/holy_arb_pick.sv
// Combinational picker: first set request at or after start_idx, wrapping.
module holy_arb_pick #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   start_idx,
  output logic [NUM_REQ-1:0] gnt_oh,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_vld
);

  logic [2*NUM_REQ-1:0] req_rot;
  logic [IDX_W:0]       pos;

  // Rotate the request vector so start_idx lands at bit 0, then take the first hit.
  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    pos     = '0;
    req_rot = {req, req} >> start_idx;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!gnt_vld && req_rot[k]) begin
        gnt_vld = 1'b1;
        pos     = {1'b0, start_idx} + (IDX_W+1)'(k);
        if (pos >= (IDX_W+1)'(NUM_REQ)) begin
          pos = pos - (IDX_W+1)'(NUM_REQ);
        end
        gnt_idx = pos[IDX_W-1:0];
        gnt_oh  = NUM_REQ'(1) << pos[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/holy_axi_rd_arbiter.sv
// Burst-granular arbiter sharing the AXI read channel (AR/R) between caches.
// Optional: define HOLY_RD_ARB_RR_EN for round-robin instead of fixed priority.
module holy_axi_rd_arbiter
  import holy_axi_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ID_W    = 4,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        s_arvalid,
  output logic [NUM_REQ-1:0]        s_arready,
  input  logic [NUM_REQ*ADDR_W-1:0] s_araddr,
  input  logic [NUM_REQ*8-1:0]      s_arlen,
  output logic [NUM_REQ-1:0]        s_rvalid,
  input  logic [NUM_REQ-1:0]        s_rready,
  output logic [DATA_W-1:0]         s_rdata,
  output logic                      s_rlast,
  output logic [ID_W-1:0]           m_arid,
  output logic [ADDR_W-1:0]         m_araddr,
  output logic [7:0]                m_arlen,
  output logic [2:0]                m_arsize,
  output logic [1:0]                m_arburst,
  output logic                      m_arvalid,
  input  logic                      m_arready,
  input  logic [ID_W-1:0]           m_rid,
  input  logic [DATA_W-1:0]         m_rdata,
  input  logic [1:0]                m_rresp,
  input  logic                      m_rlast,
  input  logic                      m_rvalid,
  output logic                      m_rready,
  output logic                      busy,
  output logic                      rid_err
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  rd_state_e          state;
  logic [IDX_W-1:0]   grant;
  logic [IDX_W-1:0]   start_idx;
  logic [NUM_REQ-1:0] pick_oh;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_vld;
  logic [ADDR_W-1:0]  sel_addr;
  logic [7:0]         sel_len;
  logic               unused_rresp;

`ifdef HOLY_RD_ARB_RR_EN
  logic [IDX_W-1:0] last_grant;

  // Search begins one past the previous winner, wrapping at NUM_REQ.
  always_comb begin
    start_idx = last_grant + IDX_W'(1);
    if (last_grant == IDX_W'(NUM_REQ - 1)) begin
      start_idx = '0;
    end
  end
`else
  assign start_idx = '0;
`endif

  holy_arb_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req       (s_arvalid),
    .start_idx (start_idx),
    .gnt_oh    (pick_oh),
    .gnt_idx   (pick_idx),
    .gnt_vld   (pick_vld)
  );

  // Select the winning requester's address and length.
  always_comb begin
    sel_addr = '0;
    sel_len  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_oh[i]) begin
        sel_addr = s_araddr[i*ADDR_W +: ADDR_W];
        sel_len  = s_arlen[i*8 +: 8];
      end
    end
  end

  // Read channel state machine with registered AR fields and error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      grant     <= '0;
      m_arvalid <= 1'b0;
      m_araddr  <= '0;
      m_arlen   <= '0;
      m_arid    <= '0;
      rid_err   <= 1'b0;
`ifdef HOLY_RD_ARB_RR_EN
      last_grant <= '0;
`endif
    end else begin
      rid_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_vld) begin
            grant     <= pick_idx;
            m_araddr  <= sel_addr;
            m_arlen   <= sel_len;
            m_arid    <= ID_W'(pick_idx);
            m_arvalid <= 1'b1;
            state     <= ST_ADDR;
`ifdef HOLY_RD_ARB_RR_EN
            last_grant <= pick_idx;
`endif
          end
        end
        ST_ADDR: begin
          if (m_arready) begin
            m_arvalid <= 1'b0;
            state     <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (m_rvalid && m_rready) begin
            rid_err <= (m_rid != ID_W'(grant));
            if (m_rlast) begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Upstream AR ready only while idle; R channel routed to the granted requester.
  always_comb begin
    s_arready = '0;
    s_rvalid  = '0;
    m_rready  = 1'b0;
    if (!rst && state == ST_IDLE) begin
      s_arready = pick_oh;
    end
    if (!rst && state == ST_DATA) begin
      s_rvalid = NUM_REQ'(m_rvalid) << grant;
      m_rready = s_rready[grant];
    end
  end

  assign s_rdata      = m_rdata;
  assign s_rlast      = m_rlast;
  assign m_arsize     = AXI_SIZE_WORD;
  assign m_arburst    = AXI_BURST_INCR;
  assign busy         = (state != ST_IDLE);
  assign unused_rresp = ^m_rresp;

endmodule

// File: tb/tb_holy_axi_rd_arbiter.sv
// Randomized bench for holy_axi_rd_arbiter against a transaction-level model.
module tb_holy_axi_rd_arbiter;

  localparam int NUM_REQ = 2;
  localparam int ID_W    = 4;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int NCYC    = 4000;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        len;
  } req_t;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NUM_REQ-1:0]        s_arvalid;
  logic [NUM_REQ-1:0]        s_arready;
  logic [NUM_REQ*ADDR_W-1:0] s_araddr;
  logic [NUM_REQ*8-1:0]      s_arlen;
  logic [NUM_REQ-1:0]        s_rvalid;
  logic [NUM_REQ-1:0]        s_rready;
  logic [DATA_W-1:0]         s_rdata;
  logic                      s_rlast;
  logic [ID_W-1:0]           m_arid;
  logic [ADDR_W-1:0]         m_araddr;
  logic [7:0]                m_arlen;
  logic [2:0]                m_arsize;
  logic [1:0]                m_arburst;
  logic                      m_arvalid;
  logic                      m_arready;
  logic [ID_W-1:0]           m_rid;
  logic [DATA_W-1:0]         m_rdata;
  logic [1:0]                m_rresp;
  logic                      m_rlast;
  logic                      m_rvalid;
  logic                      m_rready;
  logic                      busy;
  logic                      rid_err;

  holy_axi_rd_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .s_arvalid (s_arvalid),
    .s_arready (s_arready),
    .s_araddr  (s_araddr),
    .s_arlen   (s_arlen),
    .s_rvalid  (s_rvalid),
    .s_rready  (s_rready),
    .s_rdata   (s_rdata),
    .s_rlast   (s_rlast),
    .m_arid    (m_arid),
    .m_araddr  (m_araddr),
    .m_arlen   (m_arlen),
    .m_arsize  (m_arsize),
    .m_arburst (m_arburst),
    .m_arvalid (m_arvalid),
    .m_arready (m_arready),
    .m_rid     (m_rid),
    .m_rdata   (m_rdata),
    .m_rresp   (m_rresp),
    .m_rlast   (m_rlast),
    .m_rvalid  (m_rvalid),
    .m_rready  (m_rready),
    .busy      (busy),
    .rid_err   (rid_err)
  );

  always #5 clk = ~clk;

  // Reference model: one outstanding burst described by owner / AR pending / beats remaining.
  req_t              rq [NUM_REQ][$];
  int                owner;
  bit                ar_pend;
  logic [ADDR_W-1:0] exp_addr;
  logic [7:0]        exp_len;
  int                beats_left;
  int                beat;
  bit                exp_rid_err;
  bit                prev_rst;
  int                n_pass;
  int                n_checks;
  int                n_bursts;
`ifdef HOLY_RD_ARB_RR_EN
  int                rr_last;
`endif

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Winner among the requests in v according to the arbitration rule.
  function automatic int pick(input logic [NUM_REQ-1:0] v);
    int start;
`ifdef HOLY_RD_ARB_RR_EN
    start = (rr_last + 1) % NUM_REQ;
`else
    start = 0;
`endif
    for (int k = 0; k < NUM_REQ; k++) begin
      int i;
      i = (start + k) % NUM_REQ;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [DATA_W-1:0] beat_data(input logic [ADDR_W-1:0] a, input int b);
    return {a[23:0], 8'(b)};
  endfunction

  task automatic model_reset();
    owner       = -1;
    ar_pend     = 1'b0;
    beats_left  = 0;
    beat        = 0;
    exp_rid_err = 1'b0;
`ifdef HOLY_RD_ARB_RR_EN
    rr_last     = 0;
`endif
  endtask

  // Drive all DUT inputs for the coming cycle.
  task automatic drive(input int cyc);
    int push_pct;
    bit dp;
    push_pct = (cyc < 1500) ? 30 : (cyc < 3000) ? 95 : 10;
    rst = (cyc < 2) || ($urandom_range(0, 299) == 0);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rq[i].size() < 3 && $urandom_range(0, 99) < push_pct) begin
        req_t r;
        r.addr = {$urandom()} & 32'hFFFF_FFFC;
        r.len  = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(4, 7)) : 8'($urandom_range(0, 3));
        rq[i].push_back(r);
      end
      s_arvalid[i] = (rq[i].size() > 0);
      s_araddr[i*ADDR_W +: ADDR_W] = (rq[i].size() > 0) ? rq[i][0].addr : ADDR_W'($urandom());
      s_arlen[i*8 +: 8]            = (rq[i].size() > 0) ? rq[i][0].len  : 8'($urandom());
      s_rready[i] = ($urandom_range(0, 99) < 70);
    end
    m_arready = ($urandom_range(0, 99) < 50);
    m_rresp   = 2'($urandom());
    dp = (owner >= 0) && !ar_pend;
    if (dp) begin
      m_rvalid = ($urandom_range(0, 99) < 70);
      m_rdata  = beat_data(exp_addr, beat);
      m_rlast  = (beats_left == 1);
      m_rid    = ($urandom_range(0, 9) == 0) ? ID_W'(owner + 2) : ID_W'(owner);
    end else begin
      m_rvalid = ($urandom_range(0, 99) < 20);
      m_rdata  = DATA_W'($urandom());
      m_rlast  = 1'($urandom());
      m_rid    = ID_W'($urandom());
    end
  endtask

  // Compare DUT outputs with the model, then advance the model by one clock.
  task automatic check_and_update();
    int w;
    bit dp;
    bit rerr_n;
    logic [NUM_REQ-1:0] exp_oh;
    rerr_n = 1'b0;
    if (!rst) begin
      if (prev_rst) begin
        chk("rst_m_araddr", m_araddr, 0);
        chk("rst_m_arlen", m_arlen, 0);
        chk("rst_m_arid", m_arid, 0);
        chk("m_arsize", m_arsize, 3'b010);
        chk("m_arburst", m_arburst, 2'b01);
      end
      w = pick(s_arvalid);
      exp_oh = '0;
      if (owner < 0 && w >= 0) exp_oh[w] = 1'b1;
      dp = (owner >= 0) && !ar_pend;
      chk("s_arready", s_arready, exp_oh);
      chk("m_arvalid", m_arvalid, ar_pend);
      if (ar_pend) begin
        chk("m_araddr", m_araddr, exp_addr);
        chk("m_arlen", m_arlen, exp_len);
        chk("m_arid", m_arid, ID_W'(owner));
      end
      chk("busy", busy, owner >= 0);
      chk("rid_err", rid_err, exp_rid_err);
      exp_oh = '0;
      if (dp && m_rvalid) exp_oh[owner] = 1'b1;
      chk("s_rvalid", s_rvalid, exp_oh);
      chk("m_rready", m_rready, dp ? s_rready[owner] : 1'b0);
      if (dp && m_rvalid && s_rready[owner]) begin
        chk("s_rdata", s_rdata, beat_data(exp_addr, beat));
        chk("s_rlast", s_rlast, beats_left == 1);
      end
      // model advance
      if (owner < 0) begin
        if (w >= 0) begin
          owner      = w;
          ar_pend    = 1'b1;
          exp_addr   = rq[w][0].addr;
          exp_len    = rq[w][0].len;
          beats_left = int'(exp_len) + 1;
          beat       = 0;
          void'(rq[w].pop_front());
`ifdef HOLY_RD_ARB_RR_EN
          rr_last    = w;
`endif
        end
      end else if (ar_pend) begin
        if (m_arready) ar_pend = 1'b0;
      end else if (m_rvalid && s_rready[owner]) begin
        rerr_n = (m_rid != ID_W'(owner));
        beat++;
        beats_left--;
        if (beats_left == 0) begin
          owner = -1;
          n_bursts++;
        end
      end
      exp_rid_err = rerr_n;
    end else begin
      model_reset();
    end
    prev_rst = rst;
  endtask

  initial begin
    rst       = 1'b1;
    s_arvalid = '0;
    s_araddr  = '0;
    s_arlen   = '0;
    s_rready  = '0;
    m_arready = 1'b0;
    m_rid     = '0;
    m_rdata   = '0;
    m_rresp   = '0;
    m_rlast   = 1'b0;
    m_rvalid  = 1'b0;
    n_pass    = 0;
    n_checks  = 0;
    n_bursts  = 0;
    prev_rst  = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      drive(cyc);
      @(negedge clk);
      check_and_update();
      @(posedge clk);
      #1;
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
